dmem_wait_responder: RTL and testbench
======================================

// Module: dmem_wait_responder
// PURPOSE
//  Memory-side responder for the processor data-memory port (cen_n/wen_n/addr/wdata/oen_n -> q).
//  Backs a DEPTH x DATA_W register array and inserts WAIT_CYCLES programmable wait states per access.
//  Adds a ready handshake so the single-cycle core can be re-verified against a slow memory.
//  Sits between the core's memory port and the bench in place of the fixed-latency memory model.
// PARAMETERS
//  DATA_W       32  data word width
//  ADDR_W       7   word address width; DEPTH = 2**ADDR_W (128)
//  WAIT_CYCLES  0   wait states per access (0..15); 0 = zero-wait
// PORTS
//  clk      in   1       clock; all state changes on rising edge
//  rst      in   1       asynchronous reset, active-high
//  cen_n    in   1       chip enable, active-low; request present when 0
//  wen_n    in   1       write enable, active-low; 0 = write, 1 = read
//  addr     in   ADDR_W  word address
//  wdata    in   DATA_W  write data
//  oen_n    in   1       output enable, active-low
//  q        out  DATA_W  read data; q = oen_n ? 0 : q_reg (combinational gating, no tristate)
//  ready    out  1       1 = can accept a request this cycle
//  rd_cnt   out  16      completed reads (macro-dependent, see CONFIGURATION)
//  wr_cnt   out  16      completed writes (macro-dependent)
// BEHAVIOUR
//  Reset values: q_reg=0 (q=0), ready=1, state=IDLE, wait counter=0, rd_cnt=wr_cnt=0.
//  Memory array is not reset; contents survive rst.
//  Accept: rising edge with cen_n==0 && ready==1; addr, wen_n, wdata captured at that edge.
//  FSM IDLE: ready=1.
//   - accept && WAIT_CYCLES==0: perform access at the same edge, stay IDLE.
//   - accept && WAIT_CYCLES>0: latch request, cnt<=WAIT_CYCLES-1, go WAIT.
//   - cen_n==1: no state change, q_reg holds.
//  FSM WAIT: ready=0; all port inputs are ignored.
//   - cnt!=0: cnt<=cnt-1.
//   - cnt==0: perform the latched access, go IDLE (ready=1 the next cycle).
//  Access: write -> mem[addr]<=wdata, q_reg unchanged. Read -> q_reg<=mem[addr].
//  Latency: read data on q after edge (WAIT_CYCLES+1) counted from the accept edge;
//   ready is low for exactly WAIT_CYCLES cycles per access.
//  Back-to-back: a new request may be accepted on the first cycle ready=1 returns;
//   zero-wait mode accepts one request every cycle.
//  Read-after-write to the same address in the next access returns the new data (no stale read).
//  q_reg holds the last read value through writes and idle cycles.
//  oen_n affects only output gating, never FSM or array state.
//  Reset mid-WAIT: pending request discarded; a pending write is NOT committed.
//  addr spans the full DEPTH; no out-of-range case exists.
// CONFIGURATION
//  DMEM_ACCESS_CNT_EN defined:
//   - rd_cnt/wr_cnt increment on each completed read/write.
//   - Both saturate at 16'hFFFF; cleared only by rst.
//  DMEM_ACCESS_CNT_EN undefined: counters not built, rd_cnt=wr_cnt=16'h0000 constant.
// TESTING
//  1 WAIT_CYCLES=0: write 15 @0, read @0 with oen_n=0 -> q=15 after 1 edge, ready stays 1.
//  2 WAIT_CYCLES=3: read @1 (preloaded 20) -> ready low 3 cycles; q=20 after 4th edge; inputs changed in WAIT ignored.
//  3 Write 30 @4, then read @4 on the first ready cycle -> q=30; with oen_n=1 -> q=0, q_reg unchanged.
//  4 WAIT_CYCLES=2: assert rst during WAIT of a write of 99 @5 -> ready=1, q=0; later read @5 returns old value.
//  5 Zero-wait back-to-back: 128 writes (addr+1) then 128 reads -> all data match, ready never drops.
//  6 DMEM_ACCESS_CNT_EN: 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2; 65540 reads -> rd_cnt=16'hFFFF.
//    Without the macro: both counters read 0.

Source files
------------

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wait_responder
// Brief    : Data-memory responder with programmable wait states and a ready
//            handshake. Optional access counters under DMEM_ACCESS_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wait_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen_n,
  input  logic              wen_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              oen_n,
  output logic [DATA_W-1:0] q,
  output logic              ready,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int         c_DEPTH     = 2 ** ADDR_W;
  localparam bit         c_ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_CNT_LOAD  = 4'(c_ZERO_WAIT ? 0 : WAIT_CYCLES - 1);

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_WAIT = 1'b1;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_req_wr;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic [DATA_W-1:0] r_q;

  logic              w_accept;
  logic              w_do_access;
  logic              w_acc_wr;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;

  assign w_accept = (r_state == c_S_IDLE) && !cen_n;

  // Zero-wait builds serve the port directly; otherwise the latched request is used.
  assign w_do_access = c_ZERO_WAIT ? w_accept
                                   : ((r_state == c_S_WAIT) && (r_cnt == 4'd0));
  assign w_acc_wr    = c_ZERO_WAIT ? !wen_n : r_req_wr;
  assign w_acc_addr  = c_ZERO_WAIT ? addr   : r_req_addr;
  assign w_acc_wdata = c_ZERO_WAIT ? wdata  : r_req_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_S_IDLE;
      r_cnt       <= 4'd0;
      r_req_wr    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else if (r_state == c_S_IDLE) begin
      if (w_accept && !c_ZERO_WAIT) begin
        r_state     <= c_S_WAIT;
        r_cnt       <= c_CNT_LOAD;
        r_req_wr    <= !wen_n;
        r_req_addr  <= addr;
        r_req_wdata <= wdata;
      end
    end else begin
      if (r_cnt == 4'd0) begin
        r_state <= c_S_IDLE;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Array contents are deliberately not reset so they survive rst.
  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_wr) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (w_do_access && !w_acc_wr) begin
      r_q <= r_mem[w_acc_addr];
    end
  end

  assign q     = oen_n ? '0 : r_q;
  assign ready = (r_state == c_S_IDLE);

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt <= 16'h0000;
      r_wr_cnt <= 16'h0000;
    end else if (w_do_access) begin
      if (w_acc_wr) begin
        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end else begin
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`else
  assign rd_cnt = 16'h0000;
  assign wr_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wait_responder
// Brief    : Bench driving three responders (0, 3 and 2 wait states) from shared
//            inputs, checked against a transaction-level model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_wait_responder;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int NI    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cen_n = 1'b1;
  logic          wen_n = 1'b1;
  logic          oen_n = 1'b1;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] q      [NI];
  logic          ready  [NI];
  logic [15:0]   rd_cnt [NI];
  logic [15:0]   wr_cnt [NI];

  always #5 clk = ~clk;

  dmem_wait_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .wdata(wdata),
    .oen_n(oen_n), .q(q[0]), .ready(ready[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));
  dmem_wait_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .wdata(wdata),
    .oen_n(oen_n), .q(q[1]), .ready(ready[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));
  dmem_wait_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .wdata(wdata),
    .oen_n(oen_n), .q(q[2]), .ready(ready[2]), .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2]));

  // Reference model: a request accepted at edge n completes at edge n+W.
  int            c_w [NI] = '{0, 3, 2};
  logic [DW-1:0] m_mem  [NI][DEPTH];
  logic [DW-1:0] m_q    [NI];
  bit            m_pend [NI];
  bit            m_pw   [NI];
  logic [AW-1:0] m_pa   [NI];
  logic [DW-1:0] m_pd   [NI];
  int            m_done [NI];
  int            m_rd   [NI];
  int            m_wr   [NI];
  int            n_edge = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            cen_n;
    bit            wen_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            oen_n;
    logic [DW-1:0] exp_q;
    bit            exp_rdy;
  } vec_t;
  vec_t tv [11];

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  function automatic void m_access(input int i, input bit is_wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
    if (is_wr) begin
      m_mem[i][a] = d;
      if (m_wr[i] < 65535) m_wr[i]++;
    end else begin
      m_q[i] = m_mem[i][a];
      if (m_rd[i] < 65535) m_rd[i]++;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NI; i++) begin
      m_pend[i] = 1'b0;
      m_q[i]    = '0;
      m_rd[i]   = 0;
      m_wr[i]   = 0;
    end
  endfunction

  function automatic void m_edge();
    for (int i = 0; i < NI; i++) begin
      if (m_pend[i]) begin
        if (n_edge == m_done[i]) begin
          m_access(i, m_pw[i], m_pa[i], m_pd[i]);
          m_pend[i] = 1'b0;
        end
      end else if (!cen_n) begin
        if (c_w[i] == 0) begin
          m_access(i, !wen_n, addr, wdata);
        end else begin
          m_pend[i] = 1'b1;
          m_pw[i]   = !wen_n;
          m_pa[i]   = addr;
          m_pd[i]   = wdata;
          m_done[i] = n_edge + c_w[i];
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef DMEM_ACCESS_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v * 0);
`endif
  endfunction

  task automatic cmp_model();
    for (int i = 0; i < NI; i++) begin
      check("model_q",     i, q[i],            oen_n ? 32'd0 : m_q[i]);
      check("model_ready", i, 32'(ready[i]),   32'(!m_pend[i]));
      check("model_rdcnt", i, 32'(rd_cnt[i]),  exp_cnt(m_rd[i]));
      check("model_wrcnt", i, 32'(wr_cnt[i]),  exp_cnt(m_wr[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset();
    else     m_edge();
    n_edge++;
    #1;
    cmp_model();
  endtask

  task automatic drive(input bit c, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit o);
    cen_n = c;
    wen_n = w;
    addr  = a;
    wdata = d;
    oen_n = o;
  endtask

  // Holding a request 4 cycles guarantees every instance accepts it at least once.
  task automatic hold(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b0, w, a, d, 1'b0);
    repeat (4) cycle();
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (4) cycle();
  endtask

  task automatic async_reset();
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    rst = 1'b1;
    #1;
    m_reset();
    cmp_model();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b0, 7'd0,   32'd15, 1'b0, 32'd0,  1'b1};
    tv[1]  = '{1'b0, 1'b1, 7'd0,   32'd0,  1'b0, 32'd15, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 7'd0,   32'd0,  1'b0, 32'd15, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 7'd4,   32'd30, 1'b0, 32'd15, 1'b1};
    tv[4]  = '{1'b0, 1'b1, 7'd4,   32'd0,  1'b0, 32'd30, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 7'd0,   32'd0,  1'b1, 32'd0,  1'b1};
    tv[6]  = '{1'b1, 1'b1, 7'd0,   32'd0,  1'b0, 32'd30, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 7'd127, 32'd77, 1'b1, 32'd0,  1'b1};
    tv[8]  = '{1'b0, 1'b1, 7'd127, 32'd0,  1'b0, 32'd77, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 7'd0,   32'd0,  1'b1, 32'd0,  1'b1};
    tv[10] = '{1'b1, 1'b1, 7'd0,   32'd0,  1'b0, 32'd15, 1'b1};

    // Reset state
    #2;
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    rst = 1'b1;
    #1;
    m_reset();
    for (int i = 0; i < NI; i++) begin
      check("rst_q",     i, q[i],            32'd0);
      check("rst_ready", i, 32'(ready[i]),   32'd1);
      check("rst_rdcnt", i, 32'(rd_cnt[i]),  32'd0);
      check("rst_wrcnt", i, 32'(wr_cnt[i]),  32'd0);
    end
    cycle();
    cycle();
    rst = 1'b0;

    // Preload every word in all instances
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, AW'(a), 32'(a * 3 + 7), 1'b1);
      repeat (4) cycle();
    end
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (4) cycle();

    // Directed zero-wait vectors
    for (int k = 0; k < 11; k++) begin
      drive(tv[k].cen_n, tv[k].wen_n, tv[k].addr, tv[k].wdata, tv[k].oen_n);
      cycle();
      check("tv_q",     k, q[0],          tv[k].exp_q);
      check("tv_ready", k, 32'(ready[0]), 32'(tv[k].exp_rdy));
    end
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (4) cycle();

    // Three-wait read; inputs changed during WAIT must be ignored
    hold(1'b0, 7'd1, 32'd20);
    drive(1'b0, 1'b1, 7'd1, 32'd0, 1'b0);
    cycle();
    check("w3_ready_e1", 1, 32'(ready[1]), 32'd0);
    drive(1'b0, 1'b0, 7'd1, 32'd55, 1'b0);
    cycle();
    check("w3_ready_e2", 1, 32'(ready[1]), 32'd0);
    cycle();
    check("w3_ready_e3", 1, 32'(ready[1]), 32'd0);
    cycle();
    check("w3_ready_e4", 1, 32'(ready[1]), 32'd1);
    check("w3_q_e4",     1, q[1],          32'd20);
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (4) cycle();
    hold(1'b1, 7'd1, 32'd0);
    check("w3_ignored_q", 0, q[0], 32'd55);
    check("w3_ignored_q", 1, q[1], 32'd20);

    // Reset during WAIT of a write: the write must not commit
    drive(1'b0, 1'b0, 7'd5, 32'd99, 1'b0);
    cycle();
    check("rstw_ready_wait", 2, 32'(ready[2]), 32'd0);
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    rst = 1'b1;
    #1;
    m_reset();
    check("rstw_ready", 2, 32'(ready[2]), 32'd1);
    check("rstw_q",     2, q[2],          32'd0);
    repeat (3) cycle();
    rst = 1'b0;
    hold(1'b1, 7'd5, 32'd0);
    check("rstw_old", 0, q[0], 32'd99);
    check("rstw_old", 1, q[1], 32'd22);
    check("rstw_old", 2, q[2], 32'd22);

    // Zero-wait back-to-back sweep
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, AW'(a), 32'(a + 1), 1'b0);
      cycle();
      check("b2b_wr_ready", a, 32'(ready[0]), 32'd1);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b1, AW'(a), 32'd0, 1'b0);
      cycle();
      check("b2b_rd_ready", a, 32'(ready[0]), 32'd1);
      check("b2b_rd_q",     a, q[0],          32'(a + 1));
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
              32'($urandom), 1'($urandom_range(0, 3) == 0));
        cycle();
      end
    end

    // Access counters
    async_reset();
    drive(1'b0, 1'b1, 7'd3, 32'd0, 1'b0); cycle();
    drive(1'b0, 1'b0, 7'd3, 32'd8, 1'b0); cycle();
    drive(1'b0, 1'b1, 7'd9, 32'd0, 1'b0); cycle();
    drive(1'b0, 1'b0, 7'd9, 32'd6, 1'b0); cycle();
    drive(1'b0, 1'b1, 7'd3, 32'd0, 1'b0); cycle();
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (4) cycle();
`ifdef DMEM_ACCESS_CNT_EN
    check("cnt_rd", 0, 32'(rd_cnt[0]), 32'd3);
    check("cnt_wr", 0, 32'(wr_cnt[0]), 32'd2);
    drive(1'b0, 1'b1, 7'd0, 32'd0, 1'b0);
    repeat (65540) cycle();
    drive(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (4) cycle();
    check("cnt_rd_sat", 0, 32'(rd_cnt[0]), 32'h0000FFFF);
    check("cnt_wr_hold", 0, 32'(wr_cnt[0]), 32'd2);
`else
    for (int i = 0; i < NI; i++) begin
      check("cnt_rd_off", i, 32'(rd_cnt[i]), 32'd0);
      check("cnt_wr_off", i, 32'(wr_cnt[i]), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
